// File: rtl/fsm.sv
// Z-buffered span writer: reads a z-buffer line, depth-tests and interpolates one pixel
// per clock, then writes back z and framebuffer bursts. Define FSM_ZTEST_EN to enable the depth test.
module fsm #(
    parameter int unsigned STRIDE = 1024
) (
    input  logic        clk,
    input  logic        nreset,
    input  logic        start,
    input  logic [31:0] fb_addr,
    input  logic [31:0] zbuff_addr,
    input  logic [31:0] y,
    input  logic [15:0] x1,
    input  logic [15:0] x2,
    input  logic [31:0] z1,
    input  logic [31:0] z2,
    input  logic [31:0] slope,
    input  logic [31:0] rem,
    input  logic [31:0] err,
    input  logic        zread_empty,
    input  logic [31:0] zfifo_in,
    input  logic        axi_done,
    output logic        rd_req,
    output logic        wr_req,
    output logic [31:0] addr,
    output logic [1:0]  byteenable,
    output logic        read_zfifo,
    output logic        write_zfifo,
    output logic        write_befifo,
    output logic [31:0] z_out,
    output logic        read_zbuffout_fifo,
    output logic        read_be_fifo
);

    typedef enum logic [2:0] {IDLE, ZRD, CMP, ZWR, ZWAIT, FBWR, FBWAIT} state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic [31:0] r_fb_addr;
    logic [31:0] r_zb_addr;
    logic [31:0] r_line;
    logic [31:0] r_z_cur;
    logic [31:0] r_e;
    logic [31:0] r_slope;
    logic [31:0] r_rem;
    logic [15:0] r_dx;
    logic [16:0] r_cnt;

    logic        w_go;
    logic        w_pop;
    logic        w_pass;
    logic        w_last;
    logic        w_carry;
    logic [31:0] w_line;
    logic [31:0] w_dx32;
    logic [31:0] w_e_sum;
    logic [31:0] w_z_step;
    logic [31:0] w_zb_line_addr;
    logic [31:0] w_fb_line_addr;
    logic        w_unused;

    // z2 is implied by slope/rem; only the low half of y addresses a scanline.
    assign w_unused = ^{z2, y[31:16]};

    assign w_go           = start && (x2 >= x1);
    assign w_line         = 32'(y[15:0]) * STRIDE + 32'(x1);
    assign w_zb_line_addr = r_zb_addr + (r_line << 2);
    assign w_fb_line_addr = r_fb_addr + (r_line << 1);

    assign w_pop    = (r_state == CMP) && !zread_empty;
    assign w_last   = (r_cnt == {1'b0, r_dx});
    assign w_dx32   = {16'd0, r_dx};
    assign w_e_sum  = r_e + r_rem;
    assign w_carry  = (w_e_sum >= w_dx32);
    assign w_z_step = r_z_cur + r_slope;

`ifdef FSM_ZTEST_EN
    assign w_pass = (r_z_cur < zfifo_in);
`else
    assign w_pass = 1'b1;
`endif

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_fb_addr <= '0;
            r_zb_addr <= '0;
            r_line    <= '0;
            r_z_cur   <= '0;
            r_e       <= '0;
            r_slope   <= '0;
            r_rem     <= '0;
            r_dx      <= '0;
            r_cnt     <= '0;
        end else if ((r_state == IDLE) && w_go) begin
            r_fb_addr <= fb_addr;
            r_zb_addr <= zbuff_addr;
            r_line    <= w_line;
            r_z_cur   <= z1;
            r_e       <= err;
            r_slope   <= slope;
            r_rem     <= rem;
            r_dx      <= x2 - x1;
            r_cnt     <= '0;
        end else if (w_pop) begin
            // Bresenham-style step: integer slope plus a carry from the error accumulator.
            r_cnt   <= r_cnt + 17'd1;
            r_z_cur <= w_z_step + {31'd0, w_carry};
            r_e     <= w_carry ? (w_e_sum - w_dx32) : w_e_sum;
        end
    end

    always_comb begin
        w_state_next       = r_state;
        rd_req             = 1'b0;
        wr_req             = 1'b0;
        addr               = '0;
        byteenable         = 2'b00;
        read_zfifo         = 1'b0;
        write_zfifo        = 1'b0;
        write_befifo       = 1'b0;
        z_out              = '0;
        read_zbuffout_fifo = 1'b0;
        read_be_fifo       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_go) begin
                    w_state_next = ZRD;
                end
            end
            ZRD: begin
                rd_req       = 1'b1;
                addr         = w_zb_line_addr;
                w_state_next = CMP;
            end
            CMP: begin
                if (!zread_empty) begin
                    read_zfifo   = 1'b1;
                    write_zfifo  = 1'b1;
                    write_befifo = 1'b1;
                    z_out        = w_pass ? r_z_cur : zfifo_in;
                    byteenable   = w_pass ? 2'b11 : 2'b00;
                    if (w_last) begin
                        w_state_next = ZWR;
                    end
                end
            end
            ZWR: begin
                wr_req       = 1'b1;
                addr         = w_zb_line_addr;
                w_state_next = ZWAIT;
            end
            ZWAIT: begin
                read_zbuffout_fifo = 1'b1;
                if (axi_done) begin
                    w_state_next = FBWR;
                end
            end
            FBWR: begin
                wr_req       = 1'b1;
                addr         = w_fb_line_addr;
                w_state_next = FBWAIT;
            end
            FBWAIT: begin
                read_be_fifo = 1'b1;
                if (axi_done) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_fsm.sv
// Scoreboard bench for fsm: stimulus queues expected bursts/pixels from a closed-form depth
// model; a negedge monitor pops and compares every DUT request and FIFO push.
module tb_fsm;
    localparam int unsigned STRIDE = 1024;
`ifdef FSM_ZTEST_EN
    localparam bit ZT = 1'b1;
`else
    localparam bit ZT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        nreset;
    logic        start;
    logic [31:0] fb_addr, zbuff_addr, y, z1, z2, slope, rem, err, zfifo_in;
    logic [15:0] x1, x2;
    logic        zread_empty, axi_done;
    logic        rd_req, wr_req, read_zfifo, write_zfifo, write_befifo;
    logic        read_zbuffout_fifo, read_be_fifo;
    logic [31:0] addr, z_out;
    logic [1:0]  byteenable;

    always #5 clk = ~clk;

    fsm #(.STRIDE(STRIDE)) dut (
        .clk(clk), .nreset(nreset), .start(start),
        .fb_addr(fb_addr), .zbuff_addr(zbuff_addr), .y(y),
        .x1(x1), .x2(x2), .z1(z1), .z2(z2),
        .slope(slope), .rem(rem), .err(err),
        .zread_empty(zread_empty), .zfifo_in(zfifo_in), .axi_done(axi_done),
        .rd_req(rd_req), .wr_req(wr_req), .addr(addr), .byteenable(byteenable),
        .read_zfifo(read_zfifo), .write_zfifo(write_zfifo), .write_befifo(write_befifo),
        .z_out(z_out), .read_zbuffout_fifo(read_zbuffout_fifo), .read_be_fifo(read_be_fifo)
    );

    // {rd, wr, rdz, wrz, wrbe, addr, z_out, byteenable}
    typedef logic [70:0] sig_t;

    sig_t        exp_q[$];
    logic [31:0] fifo_q[$];
    int          wait_exp_q[$];
    int          n_cmp = 0, n_fail = 0;
    int          ev_cnt = 0, push_cnt = 0, ops_done = 0, ops_target = 0, wait_len = 0;
    logic [31:0] first_z = '0, last_z = '0;
    bit          first_pending = 1'b0;
    bit          wr_pend = 1'b0;
    int          cd = -1;
    bit          axi_hold = 1'b0;
    int          empty_mode = 0;

    function automatic sig_t mk_addr(input bit is_rd, input logic [31:0] a);
        return {is_rd, ~is_rd, 3'b000, a, 32'd0, 2'b00};
    endfunction

    function automatic sig_t mk_push(input logic [31:0] z, input logic [1:0] be);
        return {2'b00, 3'b111, 32'd0, z, be};
    endfunction

    function automatic logic [72:0] outs();
        return {rd_req, wr_req, addr, byteenable, read_zfifo, write_zfifo, write_befifo,
                z_out, read_zbuffout_fifo, read_be_fifo};
    endfunction

    // Depth after i steps: z1 + i*slope + floor((err + i*rem)/dx), all modulo 2^32.
    function automatic logic [31:0] model_z(input int i, input int dx);
        logic [63:0] acc;
        if (i == 0) return z1;
        acc = (64'(err) + 64'(unsigned'(i)) * 64'(rem)) / 64'(unsigned'(dx));
        return z1 + 32'(unsigned'(i)) * slope + acc[31:0];
    endfunction

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
        n_cmp++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s got=%0h required=%0h", name, got, want);
        end
    endtask

    task automatic issue_op(input int wmode, input logic [31:0] wconst);
        logic [31:0] line, zb_a, fb_a, z, w;
        bit          pass;
        int          dx;
        line = 32'(y[15:0]) * STRIDE + 32'(x1);
        zb_a = zbuff_addr + (line << 2);
        fb_a = fb_addr + (line << 1);
        $display("op: y=%0h x1=%0d x2=%0d z1=%0h slope=%0h rem=%0d err=%0d empty_mode=%0d hold=%0d",
                 y, x1, x2, z1, slope, rem, err, empty_mode, axi_hold);
        if (x2 >= x1) begin
            dx = int'(x2) - int'(x1);
            exp_q.push_back(mk_addr(1'b1, zb_a));
            for (int i = 0; i <= dx; i++) begin
                z = model_z(i, dx);
                if (wmode == 1) w = wconst;
                else if ($urandom_range(0, 1) == 1) w = z + $urandom_range(0, 2);
                else w = z - $urandom_range(0, 2);
                fifo_q.push_back(w);
                pass = ZT ? (z < w) : 1'b1;
                exp_q.push_back(mk_push(pass ? z : w, pass ? 2'b11 : 2'b00));
            end
            exp_q.push_back(mk_addr(1'b0, zb_a));
            exp_q.push_back(mk_addr(1'b0, fb_a));
            first_pending = 1'b1;
        end
    endtask

    task automatic pulse_start();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_ops(input int target, input int budget);
        int c;
        c = 0;
        while (ops_done < target && c < budget) begin
            @(posedge clk);
            c++;
        end
        n_cmp++;
        if (ops_done < target) begin
            n_fail++;
            $display("FAIL op_timeout got=%0d required=%0d", ops_done, target);
        end
        @(posedge clk); #1;
    endtask

    task automatic chk_empty(input string name);
        chk(name, 128'(exp_q.size()), 128'd0);
    endtask

    task automatic set_span(input logic [15:0] a, input logic [15:0] b);
        logic [31:0] d;
        int          dx;
        x1 = a;
        x2 = b;
        dx = int'(b) - int'(a);
        d  = z2 - z1;
        if (dx <= 0) begin
            slope = '0; rem = '0; err = '0;
        end else begin
            slope = d / 32'(unsigned'(dx));
            rem   = d % 32'(unsigned'(dx));
            err   = 32'(unsigned'((dx + 1) / 2));
        end
    endtask

    task automatic set_req018();
        fb_addr = 32'h0; zbuff_addr = 32'h1000_0000; y = 32'h0000_1234;
        x1 = 16'd0; x2 = 16'd256; z1 = 32'h0; z2 = 32'hFFFF_FFFF;
        slope = 32'h00FF_FFFF; rem = 32'd255; err = 32'd128;
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        sig_t got, want;
        int   w;
        if (nreset) begin
            if (rd_req | wr_req | read_zfifo | write_zfifo | write_befifo) begin
                got = {rd_req, wr_req, read_zfifo, write_zfifo, write_befifo, addr, z_out, byteenable};
                ev_cnt++;
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_event got=%h required=none", got);
                end else begin
                    want = exp_q.pop_front();
                    if (got !== want) begin
                        n_fail++;
                        $display("FAIL event got=%h required=%h", got, want);
                    end
                end
                if (read_zfifo && fifo_q.size() > 0) void'(fifo_q.pop_front());
                if (write_zfifo) begin
                    push_cnt++;
                    if (first_pending) begin
                        first_z = z_out;
                        first_pending = 1'b0;
                    end
                    last_z = z_out;
                end
                if (wr_req) wr_pend = 1'b1;
            end
            if (read_zbuffout_fifo | read_be_fifo) begin
                wait_len++;
                if (axi_done) begin
                    n_cmp++;
                    if (wait_exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL wait_unexpected got=%0d required=none", wait_len);
                    end else begin
                        w = wait_exp_q.pop_front();
                        if (wait_len != w) begin
                            n_fail++;
                            $display("FAIL wait_len got=%0d required=%0d", wait_len, w);
                        end
                    end
                    wait_len = 0;
                    if (read_be_fifo) ops_done++;
                end
            end
        end
    end

    // FWFT z-read FIFO model
    initial begin : drv_fifo
        bit tgl;
        tgl = 1'b0;
        zread_empty = 1'b1;
        zfifo_in = '0;
        forever begin
            @(posedge clk); #1;
            tgl = ~tgl;
            zfifo_in = (fifo_q.size() > 0) ? fifo_q[0] : 32'hDEAD_BEEF;
            zread_empty = (fifo_q.size() == 0) || (empty_mode == 1 && tgl) ||
                          (empty_mode == 2 && $urandom_range(0, 1) == 1);
        end
    end

    // AXI completion model: done asserted d cycles into each wait, or held high throughout
    initial begin : drv_axi
        int d;
        axi_done = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (wr_pend) begin
                wr_pend = 1'b0;
                d = axi_hold ? 0 : int'($urandom_range(0, 3));
                wait_exp_q.push_back(d + 1);
                cd = d;
            end
            if (axi_hold) begin
                axi_done = 1'b1;
                cd = -1;
            end else if (cd == 0) begin
                axi_done = 1'b1;
                cd = -1;
            end else begin
                axi_done = 1'b0;
                if (cd > 0) cd--;
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog got=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int pc, ev, c;
        nreset = 1'b0; start = 1'b0;
        fb_addr = '0; zbuff_addr = '0; y = '0; x1 = '0; x2 = '0;
        z1 = '0; z2 = '0; slope = '0; rem = '0; err = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", 128'(outs()), 128'd0);
        @(negedge clk);
        nreset = 1'b1;
        @(posedge clk); #1;
        chk("idle_outputs", 128'(outs()), 128'd0);

        // Long span, depth ramp 0 -> 0xFFFFFFFF
        set_req018();
        pc = push_cnt;
        issue_op(1, 32'hFFFF_FFFF);
        pulse_start();
        ops_target++;
        wait_ops(ops_target, 3000);
        chk("req018_pushes", 128'(push_cnt - pc), 128'd257);
        chk("req018_first_z", 128'(first_z), 128'h0);
        chk("req018_last_z", 128'(last_z), 128'hFFFF_FFFF);
        chk_empty("req018_leftover");

        // Twice the span length
        set_req018();
        x2 = 16'd512; slope = 32'h007F_FFFF; rem = 32'd511; err = 32'd256;
        pc = push_cnt;
        issue_op(1, 32'hFFFF_FFFF);
        pulse_start();
        ops_target++;
        wait_ops(ops_target, 3000);
        chk("req019_pushes", 128'(push_cnt - pc), 128'd513);
        chk("req019_last_z", 128'(last_z), 128'hFFFF_FFFF);
        chk_empty("req019_leftover");

        // Every stored depth is 0: nothing passes when the test is enabled
        set_req018();
        issue_op(1, 32'h0);
        pulse_start();
        ops_target++;
        wait_ops(ops_target, 3000);
        chk("req020_last_z", 128'(last_z), ZT ? 128'h0 : 128'hFFFF_FFFF);
        chk_empty("req020_leftover");

        // FIFO empty every other cycle, axi_done held high throughout
        set_req018();
        empty_mode = 1; axi_hold = 1'b1;
        pc = push_cnt;
        issue_op(1, 32'hFFFF_FFFF);
        pulse_start();
        ops_target++;
        wait_ops(ops_target, 3000);
        chk("req021_pushes", 128'(push_cnt - pc), 128'd257);
        chk("req021_last_z", 128'(last_z), 128'hFFFF_FFFF);
        chk_empty("req021_leftover");
        empty_mode = 0; axi_hold = 1'b0;

        // Reversed span is ignored
        x1 = 16'd100; x2 = 16'd50;
        ev = ev_cnt;
        issue_op(0, 32'h0);
        pulse_start();
        repeat (20) @(posedge clk);
        #1;
        chk("req022_no_events", 128'(ev_cnt - ev), 128'd0);

        // Asynchronous reset in the middle of the pixel loop
        set_req018();
        pc = push_cnt;
        issue_op(1, 32'hFFFF_FFFF);
        pulse_start();
        c = 0;
        while (push_cnt < pc + 5 && c < 1000) begin
            @(posedge clk);
            c++;
        end
        chk("reset_mid_reached", 128'(push_cnt >= pc + 5), 128'd1);
        #3;
        nreset = 1'b0;
        #1;
        chk("reset_mid_outputs", 128'(outs()), 128'd0);
        exp_q.delete(); fifo_q.delete(); wait_exp_q.delete();
        wr_pend = 1'b0; wait_len = 0; first_pending = 1'b0;
        @(posedge clk); #1;
        chk("reset_hold_outputs", 128'(outs()), 128'd0);
        @(negedge clk);
        nreset = 1'b1;
        set_req018();
        pc = push_cnt;
        issue_op(1, 32'hFFFF_FFFF);
        pulse_start();
        ops_target++;
        wait_ops(ops_target, 3000);
        chk("reset_restart_pushes", 128'(push_cnt - pc), 128'd257);
        chk_empty("reset_restart_leftover");

        // start held high: ignored while busy, re-triggers once back in IDLE
        fb_addr = 32'h2000_0000; zbuff_addr = 32'h3000_0000; y = 32'h0000_0042;
        z1 = 32'h0000_1000; z2 = 32'h0000_9000;
        set_span(16'd10, 16'd30);
        issue_op(0, 32'h0);
        issue_op(0, 32'h0);
        @(posedge clk); #1;
        start = 1'b1;
        ops_target++;
        wait_ops(ops_target, 3000);
        repeat (2) @(posedge clk);
        #1;
        start = 1'b0;
        ops_target++;
        wait_ops(ops_target, 3000);
        chk_empty("retrigger_leftover");

        // Randomized spans
        for (int k = 0; k < 25; k++) begin
            fb_addr = $urandom; zbuff_addr = $urandom; y = $urandom;
            z1 = $urandom; z2 = $urandom;
            x1 = 16'($urandom_range(10, 2000));
            if ($urandom_range(0, 9) == 0)
                set_span(x1, x1 - 16'($urandom_range(1, 5)));
            else
                set_span(x1, x1 + 16'($urandom_range(0, 40)));
            empty_mode = int'($urandom_range(0, 2));
            axi_hold = ($urandom_range(0, 1) == 1);
            issue_op(0, 32'h0);
            pulse_start();
            if (x2 >= x1) begin
                ops_target++;
                wait_ops(ops_target, 3000);
            end else begin
                repeat (10) @(posedge clk);
                #1;
            end
            chk_empty("random_leftover");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
